// File: rtl/ulbf_slave_seq_if.sv
// ============================================================================
// Module      : ulbf_slave_seq_if
// Description : BRAM Port-A bus plus read-back stream between the sequencer
//               and the beamformer slave / downstream sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ulbf_slave_seq_if;
    logic [19:0] BRAM_PORTA_addr;
    logic [31:0] BRAM_PORTA_din;
    logic [31:0] BRAM_PORTA_dout;
    logic        BRAM_PORTA_en;
    logic        BRAM_PORTA_we;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (
        output BRAM_PORTA_addr, BRAM_PORTA_din, BRAM_PORTA_en, BRAM_PORTA_we,
        output m_data, m_valid,
        input  BRAM_PORTA_dout, m_ready
    );

    modport slave (
        input  BRAM_PORTA_addr, BRAM_PORTA_din, BRAM_PORTA_en, BRAM_PORTA_we,
        input  m_data, m_valid,
        output BRAM_PORTA_dout, m_ready
    );
endinterface

`default_nettype wire

// File: rtl/ulbf_slave_seq.sv
// ============================================================================
// Module      : ulbf_slave_seq
// Description : BRAM Port-A initiator running the fixed beamformer-slave
//               bring-up sequence and streaming back a block of data words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ulbf_slave_seq #(
    parameter int          RD_LAT   = 2,
    parameter int          POLL_MAX = 1024,
    parameter logic [19:0] CSR_BASE = 20'h80000
) (
    input  wire logic        BRAM_PORTA_clk,
    input  wire logic        BRAM_PORTA_rst,
    input  wire logic        start,
    input  wire logic [11:0] niter_cfg,
    input  wire logic [15:0] rd_words,
    output logic             busy,
    output logic             done,
    output logic [1:0]       error,
    output logic [15:0]      rx_count,
    ulbf_slave_seq_if.master bus
);

    localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam int PC_W  = $clog2(POLL_MAX + 1);
    localparam logic [31:0] C_SLAVE_ID = 32'hBEEE0001;

    localparam logic [3:0] C_IDLE     = 4'd0;
    localparam logic [3:0] C_ID_RD    = 4'd1;
    localparam logic [3:0] C_RST_SET  = 4'd2;
    localparam logic [3:0] C_RST_CLR  = 4'd3;
    localparam logic [3:0] C_NITER_WR = 4'd4;
    localparam logic [3:0] C_POLL     = 4'd5;
    localparam logic [3:0] C_CNT_RD   = 4'd6;
    localparam logic [3:0] C_DATA_RD  = 4'd7;
    localparam logic [3:0] C_DATA_OUT = 4'd8;
    localparam logic [3:0] C_DONE     = 4'd9;

    logic [3:0]       r_state, w_nxt_state;
    logic [LAT_W-1:0] r_lat, w_nxt_lat;
    logic [PC_W-1:0]  r_poll, w_nxt_poll, w_poll_inc;
    logic [15:0]      r_idx, w_nxt_idx, w_idx_inc;
    logic [11:0]      r_niter;
    logic [15:0]      r_words;
    logic [19:0]      r_addr, w_bus_addr;
    logic [31:0]      r_din, w_bus_din;
    logic             r_en, r_we, w_is_rd, w_is_wr;
    logic [31:0]      r_mdata, w_nxt_mdata;
    logic             r_mvalid, w_nxt_mvalid;
    logic [1:0]       r_error, w_nxt_error;
    logic [15:0]      r_rxcnt, w_nxt_rxcnt;
    logic             r_busy, r_done, w_sample;

    // Read data is taken only when the latency counter reaches RD_LAT.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_lat    = '0;
        w_nxt_poll   = r_poll;
        w_nxt_idx    = r_idx;
        w_nxt_mdata  = r_mdata;
        w_nxt_mvalid = r_mvalid;
        w_nxt_error  = r_error;
        w_nxt_rxcnt  = r_rxcnt;
        w_sample     = (r_lat == LAT_W'(RD_LAT));
        w_poll_inc   = r_poll + 1'b1;
        w_idx_inc    = r_idx + 16'd1;
        case (r_state)
            C_IDLE: begin
                if (start) begin
                    w_nxt_state = C_ID_RD;
                    w_nxt_error = 2'd0;
                end
            end
            C_ID_RD: begin
                if (!w_sample) begin
                    w_nxt_lat = r_lat + 1'b1;
                end else if (bus.BRAM_PORTA_dout != C_SLAVE_ID) begin
                    w_nxt_error = 2'd1;
                    w_nxt_state = C_DONE;
                end else begin
                    w_nxt_state = C_RST_SET;
                end
            end
            C_RST_SET:  w_nxt_state = C_RST_CLR;
            C_RST_CLR:  w_nxt_state = C_NITER_WR;
            C_NITER_WR: begin
                w_nxt_state = C_POLL;
                w_nxt_poll  = '0;
            end
            C_POLL: begin
                if (!w_sample) begin
                    w_nxt_lat = r_lat + 1'b1;
                end else if (bus.BRAM_PORTA_dout[0]) begin
                    w_nxt_state = C_CNT_RD;
                end else if (w_poll_inc == PC_W'(POLL_MAX)) begin
                    w_nxt_error = 2'd2;
                    w_nxt_state = C_DONE;
                end else begin
                    w_nxt_poll = w_poll_inc;
                end
            end
            C_CNT_RD: begin
                if (!w_sample) begin
                    w_nxt_lat = r_lat + 1'b1;
                end else begin
                    w_nxt_rxcnt = bus.BRAM_PORTA_dout[15:0];
                    w_nxt_idx   = 16'd0;
                    w_nxt_state = (r_words == 16'd0) ? C_DONE : C_DATA_RD;
                end
            end
            C_DATA_RD: begin
                if (!w_sample) begin
                    w_nxt_lat = r_lat + 1'b1;
                end else begin
                    w_nxt_mdata  = bus.BRAM_PORTA_dout;
                    w_nxt_mvalid = 1'b1;
                    w_nxt_state  = C_DATA_OUT;
                end
            end
            C_DATA_OUT: begin
                if (bus.m_ready) begin
                    w_nxt_mvalid = 1'b0;
                    w_nxt_idx    = w_idx_inc;
                    w_nxt_state  = (w_idx_inc == r_words) ? C_DONE : C_DATA_RD;
                end
            end
            C_DONE:  w_nxt_state = C_IDLE;
            default: w_nxt_state = C_IDLE;
        endcase
    end

    // Bus drive is registered from the next state, so en/addr line up with it.
    always_comb begin
        w_bus_addr = r_addr;
        w_bus_din  = r_din;
        w_is_rd    = 1'b0;
        w_is_wr    = 1'b0;
        case (w_nxt_state)
            C_ID_RD:    begin w_bus_addr = CSR_BASE;          w_is_rd = 1'b1; end
            C_RST_SET:  begin w_bus_addr = CSR_BASE + 20'h04; w_bus_din = 32'd1; w_is_wr = 1'b1; end
            C_RST_CLR:  begin w_bus_addr = CSR_BASE + 20'h04; w_bus_din = 32'd0; w_is_wr = 1'b1; end
            C_NITER_WR: begin
                w_bus_addr = CSR_BASE + 20'h0C;
                w_bus_din  = {20'd0, r_niter};
                w_is_wr    = 1'b1;
            end
            C_POLL:     begin w_bus_addr = CSR_BASE + 20'h20; w_is_rd = 1'b1; end
            C_CNT_RD:   begin w_bus_addr = CSR_BASE + 20'h24; w_is_rd = 1'b1; end
            C_DATA_RD:  begin w_bus_addr = {2'b00, w_nxt_idx, 2'b00}; w_is_rd = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge BRAM_PORTA_clk or posedge BRAM_PORTA_rst) begin
        if (BRAM_PORTA_rst) begin
            r_state  <= C_IDLE;
            r_lat    <= '0;
            r_poll   <= '0;
            r_idx    <= '0;
            r_niter  <= '0;
            r_words  <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_en     <= 1'b0;
            r_we     <= 1'b0;
            r_mdata  <= '0;
            r_mvalid <= 1'b0;
            r_error  <= '0;
            r_rxcnt  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_lat    <= w_nxt_lat;
            r_poll   <= w_nxt_poll;
            r_idx    <= w_nxt_idx;
            r_addr   <= w_bus_addr;
            r_din    <= w_bus_din;
            r_en     <= w_is_wr || (w_is_rd && (w_nxt_lat == '0));
            r_we     <= w_is_wr;
            r_mdata  <= w_nxt_mdata;
            r_mvalid <= w_nxt_mvalid;
            r_error  <= w_nxt_error;
            r_rxcnt  <= w_nxt_rxcnt;
            r_busy   <= (w_nxt_state != C_IDLE);
            r_done   <= (w_nxt_state == C_DONE);
            if (r_state == C_IDLE && start) begin
                r_niter <= niter_cfg;
                r_words <= rd_words;
            end
        end
    end

    assign bus.BRAM_PORTA_addr = r_addr;
    assign bus.BRAM_PORTA_din  = r_din;
    assign bus.BRAM_PORTA_en   = r_en;
    assign bus.BRAM_PORTA_we   = r_we;
    assign bus.m_data          = r_mdata;
    assign bus.m_valid         = r_mvalid;
    assign busy                = r_busy;
    assign done                = r_done;
    assign error               = r_error;
    assign rx_count            = r_rxcnt;

endmodule

`default_nettype wire

// File: tb/tb_ulbf_slave_seq.sv
// ============================================================================
// Module      : tb_ulbf_slave_seq
// Description : Directed bench with a pipelined beamformer-slave BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ulbf_slave_seq;
    localparam int RD_LAT   = 2;
    localparam int POLL_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] niter_cfg = '0;
    logic [15:0] rd_words = '0;
    logic        busy, done;
    logic [1:0]  error;
    logic [15:0] rx_count;

    ulbf_slave_seq_if bus();

    ulbf_slave_seq #(.RD_LAT(RD_LAT), .POLL_MAX(POLL_MAX), .CSR_BASE(20'h80000)) dut (
        .BRAM_PORTA_clk(clk),
        .BRAM_PORTA_rst(rst),
        .start(start),
        .niter_cfg(niter_cfg),
        .rd_words(rd_words),
        .busy(busy),
        .done(done),
        .error(error),
        .rx_count(rx_count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Slave model: response appears exactly RD_LAT cycles after the issue cycle.
    logic [31:0] slave_id = 32'hBEEE0001;
    int          rx_after = 6;
    int          pcount = 0;
    logic [31:0] pipe [RD_LAT];

    function automatic logic [31:0] resp(input logic [19:0] a, input int pc);
        case (a)
            20'h80000: return slave_id;
            20'h80020: return (pc + 1 >= rx_after) ? 32'd1 : 32'd0;
            20'h80024: return 32'h0000_0123;
            default:   return a[19] ? 32'h0 : (32'hCAFE0000 | {12'd0, a});
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.BRAM_PORTA_en && !bus.BRAM_PORTA_we) begin
            pipe[0] <= resp(bus.BRAM_PORTA_addr, pcount);
            if (bus.BRAM_PORTA_addr == 20'h80020) pcount <= pcount + 1;
        end else begin
            pipe[0] <= 32'hBAD0BAD0;
        end
        pipe[1] <= pipe[0];
    end
    assign bus.BRAM_PORTA_dout = pipe[RD_LAT-1];

    // Bus / stream monitor and ready generator
    int          cyc = 0;
    logic [19:0] la[$];
    logic        lw[$];
    logic [31:0] ld[$];
    int          lc[$];
    logic [31:0] beats[$];
    int          stall_beat = -1;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          hold_bad = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] held = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.BRAM_PORTA_en) begin
            la.push_back(bus.BRAM_PORTA_addr);
            lw.push_back(bus.BRAM_PORTA_we);
            ld.push_back(bus.BRAM_PORTA_din);
            lc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (bus.m_valid) begin
            if (beats.size() == stall_beat && stall_left > 0) begin
                if (stall_seen > 0 && bus.m_data !== held) hold_bad = hold_bad + 1;
                if (bus.BRAM_PORTA_en) hold_bad = hold_bad + 1;
                held = bus.m_data;
                stall_seen = stall_seen + 1;
                stall_left = stall_left - 1;
                bus.m_ready = 1'b0;
            end else begin
                bus.m_ready = 1'b1;
                beats.push_back(bus.m_data);
            end
        end else begin
            bus.m_ready = 1'b1;
        end
    end

    task automatic clear_logs();
        la.delete(); lw.delete(); ld.delete(); lc.delete(); beats.delete();
        pcount = 0; stall_seen = 0; hold_bad = 0;
    endtask

    // Start held for two cycles (second is ignored); inputs perturbed after acceptance.
    task automatic run_seq(input logic [11:0] n, input logic [15:0] w, output bit ok);
        clear_logs();
        @(negedge clk);
        niter_cfg = n; rd_words = w; start = 1'b1;
        @(negedge clk);
        niter_cfg = 12'hFFF; rd_words = 16'd9;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL done_timeout: done=%b required 1", done); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, bus.m_valid, bus.BRAM_PORTA_en, bus.BRAM_PORTA_we} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: busy/done/mv/en/we=%b required 00000",
                {busy, done, bus.m_valid, bus.BRAM_PORTA_en, bus.BRAM_PORTA_we});
        end
        total++;
        if (error !== 2'd0 || rx_count !== 16'd0) begin
            bad++; $display("FAIL reset_status: error=%0d rx_count=%h required 0/0000", error, rx_count);
        end
        total++;
        if (bus.m_data !== 32'd0 || bus.BRAM_PORTA_addr !== 20'd0 || bus.BRAM_PORTA_din !== 32'd0) begin
            bad++; $display("FAIL reset_data: m_data=%h addr=%h din=%h required 0", bus.m_data,
                bus.BRAM_PORTA_addr, bus.BRAM_PORTA_din);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        bit ok;
        int dc;
        logic [19:0] ea [14] = '{20'h80000, 20'h80004, 20'h80004, 20'h8000C,
                                 20'h80020, 20'h80020, 20'h80020, 20'h80020, 20'h80020, 20'h80020,
                                 20'h80024, 20'h00000, 20'h00004, 20'h00008};
        logic        ew [14] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [31:0] ed [14] = '{0, 1, 0, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        dc = done_cnt;
        run_seq(12'h00A, 16'd4, ok);
        total++;
        if (error !== 2'd0 || rx_count !== 16'h0123) begin
            bad++; $display("FAIL nom_status: error=%0d rx_count=%h required 0/0123", error, rx_count);
        end
        total++;
        if (la.size() != 15) begin
            bad++; $display("FAIL nom_trace_len: accesses=%0d required 15", la.size());
        end
        for (int i = 0; i < 14; i++) begin
            total++;
            if (la.size() <= i || la[i] !== ea[i] || lw[i] !== ew[i] || (ew[i] && ld[i] !== ed[i])) begin
                bad++;
                if (la.size() > i) $display("FAIL nom_trace[%0d]: addr=%h we=%b din=%h required %h/%b/%h",
                    i, la[i], lw[i], ld[i], ea[i], ew[i], ed[i]);
                else $display("FAIL nom_trace[%0d]: missing required %h", i, ea[i]);
            end
        end
        total++;
        if (la.size() < 15 || la[14] !== 20'h0000C || lw[14] !== 1'b0) begin
            bad++; $display("FAIL nom_trace_last: last access not read of 0000C, got %0d accesses", la.size());
        end
        total++;
        if (beats.size() != 4) begin
            bad++; $display("FAIL nom_beats: beats=%0d required 4", beats.size());
        end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            total++;
            if (beats[i] !== (32'hCAFE0000 | 32'(4 * i))) begin
                bad++; $display("FAIL nom_beat[%0d]: got %h required %h", i, beats[i], 32'hCAFE0000 | 32'(4 * i));
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - dc != 1) begin
            bad++; $display("FAIL nom_done_pulse: done=%b busy=%b pulses=%0d required 0/0/1", done, busy, done_cnt - dc);
        end
    endtask

    task automatic test_id_mismatch();
        bit ok;
        slave_id = 32'hDEAD0000;
        run_seq(12'h001, 16'd4, ok);
        total++;
        if (error !== 2'd1) begin
            bad++; $display("FAIL id_error: error=%0d required 1", error);
        end
        total++;
        if (la.size() != 1 || lw[0] !== 1'b0) begin
            bad++; $display("FAIL id_trace: accesses=%0d required single read", la.size());
        end
        slave_id = 32'hBEEE0001;
    endtask

    task automatic test_timeout();
        bit ok;
        int polls = 0;
        rx_after = 1000;
        run_seq(12'h002, 16'd4, ok);
        foreach (la[i]) if (la[i] == 20'h80020) polls++;
        total++;
        if (error !== 2'd2) begin
            bad++; $display("FAIL to_error: error=%0d required 2", error);
        end
        total++;
        if (polls != POLL_MAX || la.size() != 12 || beats.size() != 0) begin
            bad++; $display("FAIL to_polls: polls=%0d accesses=%0d beats=%0d required 8/12/0",
                polls, la.size(), beats.size());
        end
        rx_after = 6;
    endtask

    task automatic test_backpressure();
        bit ok;
        stall_beat = 1; stall_left = 7;
        run_seq(12'h003, 16'd4, ok);
        total++;
        if (stall_seen != 7 || hold_bad != 0) begin
            bad++; $display("FAIL bp_hold: stall_cycles=%0d hold_errors=%0d required 7/0", stall_seen, hold_bad);
        end
        total++;
        if (beats.size() != 4 || beats[0] !== 32'hCAFE0000 || beats[1] !== 32'hCAFE0004 ||
            beats[2] !== 32'hCAFE0008 || beats[3] !== 32'hCAFE000C) begin
            bad++; $display("FAIL bp_beats: count=%0d required 4 in-order beats CAFE0000..C", beats.size());
        end
        total++;
        if (error !== 2'd0) begin
            bad++; $display("FAIL bp_error: error=%0d required 0", error);
        end
        stall_beat = -1; stall_left = 0;
    endtask

    task automatic test_zero_words();
        bit ok;
        int n;
        run_seq(12'h004, 16'd0, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n = la.size();
        total++;
        if (n != 11 || beats.size() != 0) begin
            bad++; $display("FAIL zw_trace: accesses=%0d beats=%0d required 11/0", n, beats.size());
        end
        total++;
        if (n == 0 || la[n-1] !== 20'h80024 || done_cyc - lc[n-1] != RD_LAT + 1) begin
            bad++; $display("FAIL zw_done_timing: cycles from CNT_RD issue to done=%0d required %0d",
                (n == 0) ? -1 : done_cyc - lc[n-1], RD_LAT + 1);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL zw_start_in_done: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        clear_logs();
        stall_beat = 0; stall_left = 1000;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            seen = bus.m_valid;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rm_reach_out: m_valid=%b required 1", bus.m_valid); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, bus.m_valid, bus.BRAM_PORTA_en, bus.BRAM_PORTA_we} !== 5'b0 || error !== 2'd0 ||
            rx_count !== 16'd0 || bus.m_data !== 32'd0 || bus.BRAM_PORTA_addr !== 20'd0 ||
            bus.BRAM_PORTA_din !== 32'd0) begin
            bad++; $display("FAIL rm_async_clear: busy=%b mv=%b rx=%h mdata=%h addr=%h required all 0",
                busy, bus.m_valid, rx_count, bus.m_data, bus.BRAM_PORTA_addr);
        end
        stall_left = 0; stall_beat = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_seq(12'h00A, 16'd4, ok);
        total++;
        if (la.size() != 15 || la[0] !== 20'h80000 || lw[0] !== 1'b0) begin
            bad++; $display("FAIL rm_restart: accesses=%0d required 15 starting with read of 80000", la.size());
        end
        total++;
        if (error !== 2'd0 || rx_count !== 16'h0123 || beats.size() != 4) begin
            bad++; $display("FAIL rm_result: error=%0d rx=%h beats=%0d required 0/0123/4", error, rx_count, beats.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_id_mismatch();
        test_timeout();
        test_backpressure();
        test_zero_words();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ulbf_slave_seq.md
Name: ulbf_slave_seq

Overview:
- BRAM-port initiator that drives the beamformer slave's 32-bit BRAM Port-A interface, i.e. the requester side of that responder.
- On `start` it runs a fixed sequence, then stops:
  - check the slave ID;
  - pulse the slave reset;
  - program niter;
  - poll rxdone;
  - read rxram_counter;
  - read back a block of data-RAM words and stream them out on a valid/ready port.
- Used by the on-chip self-test and bring-up path in place of the AXI BRAM controller.

Parameters:
- RD_LAT, 2, cycles from the read-issue cycle to the cycle in which BRAM_PORTA_dout is sampled; address is held stable throughout.
- POLL_MAX, 1024, maximum number of status reads before timeout error.
- CSR_BASE, 20'h80000, CSR window base (address bit 19 set).

Ports:
- BRAM_PORTA_clk  in  1  sole clock.
- BRAM_PORTA_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle sequence request; ignored while busy.
- niter_cfg  in  12  value written to the niter register.
- rd_words  in  16  number of 32-bit data words to read back; 0 means skip.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at sequence end, success or error.
- error  out  2  0 = ok, 1 = ID mismatch, 2 = poll timeout; held until next start.
- rx_count  out  16  rxram_counter value captured from CSR 0x24.
- m_data  out  32  read-back data word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- BRAM_PORTA_addr  out  20  byte address.
- BRAM_PORTA_din  out  32  write data.
- BRAM_PORTA_dout  in  32  read data.
- BRAM_PORTA_en  out  1  access enable.
- BRAM_PORTA_we  out  1  write enable.

Behaviour:
- Reset (async): state IDLE; addr, din, en, we = 0; busy, done, m_valid = 0; error = 0; rx_count = 0; m_data = 0; poll and word counters = 0. Reset mid-sequence aborts immediately; no further bus activity.
- Write access:
  - one cycle with en=1, we=1, addr and din valid;
  - next state follows in the next cycle.
- Read access:
  - en=1, we=0 for exactly one issue cycle T;
  - addr held constant T..T+RD_LAT;
  - dout sampled at the clock edge ending cycle T+RD_LAT;
  - en=0 during wait cycles.
- State sequence:
  - IDLE -> ID_RD on start: read CSR_BASE+0x00. Mismatch with 32'hBEEE0001 -> error=1 -> DONE.
  - RST_SET: write CSR_BASE+0x04 = 1.
  - RST_CLR: write CSR_BASE+0x04 = 0.
  - NITER_WR: write CSR_BASE+0x0C = {20'd0, niter_cfg}.
  - POLL: read CSR_BASE+0x20, back-to-back.
    - dout[0]=1 -> CNT_RD.
    - Otherwise increment poll count; if count reaches POLL_MAX without seeing dout[0]=1 -> error=2 -> DONE.
  - CNT_RD: read CSR_BASE+0x24; rx_count <= dout[15:0]. If rd_words=0 -> DONE, else DATA_RD with word index i=0.
  - DATA_RD: read byte address 4*i (bit 19 clear); capture into m_data; m_valid<=1 -> DATA_OUT.
  - DATA_OUT: hold m_data and m_valid until m_ready=1 in the same cycle.
    - On that handshake m_valid<=0 and i increments.
    - i = rd_words -> DONE; else DATA_RD.
    - No bus access while waiting.
  - DONE: done=1 for one cycle, busy<=0 -> IDLE.
- Inputs are latched at start acceptance: niter_cfg and rd_words changes mid-sequence have no effect.
- Data addressing:
  - 4*i uses 18 bits, so rd_words up to 65535 is valid.
  - Addresses alternate 64-bit halves via bit 2.
- start asserted in the same cycle as DONE is ignored; start is accepted only in IDLE.

Test Plan:
- Nominal:
  - Stimulus: slave model with ID 0xBEEE0001, rxdone rising after 5 polls, counter 0x0123, niter_cfg=0x00A, rd_words=4, m_ready=1.
  - Bus trace: writes 0x80004=1, 0x80004=0, 0x8000C=0xA; 6 reads of 0x80020; read 0x80024; reads at 0x0, 0x4, 0x8, 0xC.
  - Outputs: rx_count=0x0123, 4 beats matching RAM, done pulse, error=0.
- ID mismatch:
  - Stimulus: ID reads 0xDEAD0000.
  - Response: no writes issued; done, error=1.
- Timeout:
  - Stimulus: rxdone never set, POLL_MAX=8.
  - Response: exactly 8 status reads; done, error=2.
- Backpressure:
  - Stimulus: m_ready low for 7 cycles on beat 2.
  - Response: m_data and m_valid held stable; no bus activity; beats in order.
- rd_words=0:
  - Response: no data reads; done the cycle after CNT_RD completes.
- Async reset mid-DATA_OUT:
  - Stimulus: assert BRAM_PORTA_rst.
  - Response: all outputs zero immediately; a start after reset release runs the full sequence from ID_RD.
